keypad_scan_fifo: RTL
=====================

// Module: keypad_scan_fifo
// PURPOSE
//  Parametrised matrix-keypad scanner for the MCU I/O subsystem; next generation of the fixed 4x4 keypad decode.
//  Drives one column low at a time and samples the rows through a synchroniser.
//  Debounces every key independently and queues key events in a show-ahead FIFO read by the CPU I/O port.
// PARAMETERS
//  ROWS        4     keypad row inputs
//  COLS        4     keypad column outputs
//  SCAN_DIV    1000  cycles each column is driven before sampling (>=3)
//  DEBOUNCE    4     consecutive equal samples needed to change a key's state (>=1)
//  FIFO_DEPTH  8     event FIFO entries (power of 2)
//  CODE_W      8     event code width; needs CODE_W-1 >= clog2(ROWS*COLS)
// PORTS
//  clk          in   1                      system clock, rising edge
//  rst          in   1                      synchronous reset, active-low
//  en           in   1                      scan enable
//  keypad_rows  in   ROWS                   row lines, pulled up; 0 = pressed key on the driven column
//  keypad_cols  out  COLS                   column drive, active-low one-cold
//  key_code     out  CODE_W                 FIFO head: [CODE_W-1] = release flag, low bits = row*COLS+col
//  key_valid    out  1                      FIFO not empty
//  key_pop      in   1                      dequeue head; ignored when key_valid=0
//  fifo_count   out  clog2(FIFO_DEPTH+1)    entries held
//  overflow     out  1                      sticky: an event was dropped
//  clr_ovf      in   1                      clears overflow
// BEHAVIOUR
//  Reset (rst=0 at posedge) sets:
//   - keypad_cols all 1s; column index 0; FSM IDLE
//   - all debounce counters 0; all keys released
//   - FIFO empty: key_valid=0, key_code=0, fifo_count=0, overflow=0
//  Reset mid-scan or mid-emit drops any pending event.
//  keypad_rows passes through a 2-FF synchroniser before use.
//  FSM:
//   - IDLE: cols all 1s. en=1 -> DRIVE with col=0, cnt=0.
//   - DRIVE: cols[col]=0, all others 1; cnt counts 0..SCAN_DIV-1. At cnt=SCAN_DIV-1, latch the synchronised rows into samp -> EMIT.
//   - EMIT: lasts ROWS cycles, row r=0..ROWS-1, one row per cycle; column stays driven.
//  Per key (r,col) in EMIT:
//   - If samp[r] matches the debounced state: reset its counter to 0.
//   - Otherwise increment the counter. On reaching DEBOUNCE, toggle the state, reset the counter, and raise an event this cycle.
//   - Event code = {release, (r*COLS+col)}, zero-extended.
//   - After row ROWS-1: col wraps COLS-1 -> 0 -> DRIVE.
//   - At most one push per cycle.
//  en=0 in any state: next cycle IDLE, col=0, no event. Debounce state is held. FIFO still readable.
//  Frame = COLS*(SCAN_DIV+ROWS) cycles. A stable press yields its event in frame DEBOUNCE after the first pressed sample.
//  FIFO, show-ahead (key_code/key_valid valid from the cycle after the push):
//   - Push when not full: write the entry.
//   - Push when full without a pop: drop the event, set overflow.
//   - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
//   - Pop when empty: ignored.
//   - Pointers wrap modulo FIFO_DEPTH.
//  clr_ovf clears overflow. If clr_ovf coincides with a drop, overflow ends at 1.
// CONFIGURATION
//  KEYPAD_RELEASE_EVENTS_EN:
//   - Defined: a debounced release pushes code with bit CODE_W-1=1.
//   - Undefined: releases update debounce state only; no push; bit CODE_W-1 is always 0.
// TESTING
//  (ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4, CODE_W=8)
//  1 rst=0 two cycles, en=1 -> cols=4'b1111 during reset, key_valid=0, fifo_count=0; then cols cycle 1110,1101,1011,0111, each 8 cycles.
//  2 rows=4'b1101 while col2 driven, held 3 frames -> exactly one event 8'h06, key_valid=1, fifo_count=1. key_pop -> key_valid=0.
//  3 Same key pressed for 1 frame only, then released -> no event, fifo_count stays 0.
//  4 Five distinct keys pressed, no pops -> fifo_count=4, overflow=1, key_code = first key. clr_ovf -> overflow=0.
//     FIFO full, key_pop asserted in the same cycle as a push -> count=4, overflow stays 0.
//  5 Release key 6:
//     - With KEYPAD_RELEASE_EVENTS_EN: event 8'h86.
//     - Without: no event.
//     en=0 mid-DRIVE -> cols=4'b1111 next cycle, no event.
//  6 rst=0 during EMIT with a key mid-debounce -> all outputs at reset values; after reset, the key needs a full DEBOUNCE frames again.

Source files
------------

// File: rtl/keypad_scan_fifo.sv
// Matrix-keypad scanner: one-cold column drive, 2-FF row synchroniser, per-key debounce, show-ahead event FIFO.
// Optional feature macro: KEYPAD_RELEASE_EVENTS_EN (queue debounced releases with bit CODE_W-1 set).
module keypad_scan_fifo #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CODE_W     = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [ROWS-1:0]                   keypad_rows,
    output logic [COLS-1:0]                   keypad_cols,
    output logic [CODE_W-1:0]                 key_code,
    output logic                              key_valid,
    input  logic                              key_pop,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow,
    input  logic                              clr_ovf
);

    localparam int NKEYS = ROWS * COLS;
    localparam int IDX_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    state_t            state_r;
    logic [COL_W-1:0]  col_r;
    logic [ROW_W-1:0]  row_r;
    logic [DIV_W-1:0]  div_r;
    logic [COLS-1:0]   cols_r;
    logic [ROWS-1:0]   rows_meta_r;
    logic [ROWS-1:0]   rows_sync_r;
    logic [ROWS-1:0]   samp_r;

    logic [DB_W-1:0]   db_cnt_r [NKEYS];
    logic [NKEYS-1:0]  pressed_r;

    logic [CODE_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CODE_W-1:0] key_code_r;
    logic              key_valid_r;
    logic              ovf_r;

    logic [IDX_W-1:0]  key_idx_s;
    logic              pressed_samp_s;
    logic [DB_W-1:0]   db_inc_s;
    logic              emit_act_s;
    logic              mismatch_s;
    logic              toggle_s;
    logic              push_s;
    logic [CODE_W-1:0] push_code_s;
    logic              pop_s;
    logic              full_s;
    logic              wr_s;
    logic              drop_s;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [CODE_W-1:0] head_nxt_s;
    logic [COL_W-1:0]  col_nxt_s;

    function automatic logic [COLS-1:0] col_drive(input logic [COL_W-1:0] c);
        logic [COLS-1:0] one_hot;
        one_hot    = {COLS{1'b0}};
        one_hot[c] = 1'b1;
        return ~one_hot;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign keypad_cols = cols_r;
    assign key_code    = key_code_r;
    assign key_valid   = key_valid_r;
    assign fifo_count  = count_r;
    assign overflow    = ovf_r;

    // Debounce decision for the key addressed by the current EMIT row, plus FIFO next-state.
    always_comb begin
        key_idx_s      = IDX_W'(int'(row_r) * COLS + int'(col_r));
        pressed_samp_s = ~samp_r[row_r];
        db_inc_s       = db_cnt_r[key_idx_s] + DB_W'(1);
        emit_act_s     = (state_r == ST_EMIT) && en;
        mismatch_s     = (pressed_samp_s != pressed_r[key_idx_s]);
        toggle_s       = emit_act_s && mismatch_s && (db_inc_s == DB_MAX);
        col_nxt_s      = (col_r == COL_LAST) ? COL_W'(0) : col_r + COL_W'(1);

        push_code_s                 = {CODE_W{1'b0}};
        push_code_s[IDX_W-1:0]      = key_idx_s;
`ifdef KEYPAD_RELEASE_EVENTS_EN
        push_s                      = toggle_s;
        push_code_s[CODE_W-1]       = ~pressed_samp_s;
`else
        push_s                      = toggle_s && pressed_samp_s;
`endif

        pop_s        = key_pop && (count_r != {CNT_W{1'b0}});
        full_s       = (count_r == DEPTH_C);
        wr_s         = push_s && (!full_s || pop_s);
        drop_s       = push_s && full_s && !pop_s;
        rd_ptr_nxt_s = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;

        case ({wr_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase

        // The new head may be the entry being written this very cycle.
        if (count_nxt_s == {CNT_W{1'b0}}) begin
            head_nxt_s = {CODE_W{1'b0}};
        end else if (wr_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_nxt_s = push_code_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Two-flop synchroniser for the asynchronous row lines.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rows_meta_r <= {ROWS{1'b1}};
            rows_sync_r <= {ROWS{1'b1}};
        end else begin
            rows_meta_r <= keypad_rows;
            rows_sync_r <= rows_meta_r;
        end
    end

    // Scan FSM: column drive, settle counter, row sample latch and EMIT row walk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            col_r   <= '0;
            row_r   <= '0;
            div_r   <= '0;
            samp_r  <= {ROWS{1'b1}};
            cols_r  <= {COLS{1'b1}};
        end else if (!en) begin
            state_r <= ST_IDLE;
            col_r   <= '0;
            row_r   <= '0;
            div_r   <= '0;
            cols_r  <= {COLS{1'b1}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_DRIVE;
                    col_r   <= '0;
                    div_r   <= '0;
                    cols_r  <= col_drive(COL_W'(0));
                end
                ST_DRIVE: begin
                    if (div_r == DIV_LAST) begin
                        samp_r  <= rows_sync_r;
                        row_r   <= '0;
                        state_r <= ST_EMIT;
                    end else begin
                        div_r <= div_r + DIV_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (row_r == ROW_LAST) begin
                        row_r   <= '0;
                        div_r   <= '0;
                        col_r   <= col_nxt_s;
                        cols_r  <= col_drive(col_nxt_s);
                        state_r <= ST_DRIVE;
                    end else begin
                        row_r <= row_r + ROW_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    col_r   <= '0;
                    row_r   <= '0;
                    div_r   <= '0;
                    cols_r  <= {COLS{1'b1}};
                end
            endcase
        end
    end

    // Per-key debounce counters and debounced pressed state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NKEYS; k++) begin
                db_cnt_r[k] <= '0;
            end
            pressed_r <= '0;
        end else if (emit_act_s) begin
            if (!mismatch_s) begin
                db_cnt_r[key_idx_s] <= '0;
            end else if (toggle_s) begin
                db_cnt_r[key_idx_s]  <= '0;
                pressed_r[key_idx_s] <= pressed_samp_s;
            end else begin
                db_cnt_r[key_idx_s] <= db_inc_s;
            end
        end
    end

    // Event FIFO storage; pointers guard it so it needs no reset.
    always_ff @(posedge clk) begin
        if (rst && wr_s) begin
            mem_r[wr_ptr_r] <= push_code_s;
        end
    end

    // FIFO pointers, occupancy, registered show-ahead head and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            key_code_r  <= '0;
            key_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            key_code_r  <= head_nxt_s;
            key_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (clr_ovf) begin
                ovf_r <= 1'b0;
            end
        end
    end

endmodule
